// File: rtl/alu_decode_stage.sv
// rtl/alu_decode_stage.sv - RV32I decode stage producing ALU op, operand selects and control flags
// Decoded bundles land in a main register backed by one skid entry so in_ready stays a flop output.
module alu_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [3:0]      o_alu_op,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rd,
  output logic [XLEN-1:0] o_imm,
  output logic            o_src1_pc,
  output logic            o_src2_imm,
  output logic            o_reg_write,
  output logic            o_mem_read,
  output logic            o_mem_write,
  output logic            o_jump,
  output logic            o_branch,
  output logic [2:0]      o_branch_cond,
  output logic            o_illegal,
  output logic [XLEN-1:0] o_pc_out
);

  typedef struct packed {
    logic [3:0]      alu_op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            src1_pc;
    logic            src2_imm;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic [2:0]      branch_cond;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } bundle_t;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SLT = 4'd3,
                         OP_SLTU = 4'd4, OP_XOR = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                         OP_OR = 4'd8, OP_AND = 4'd9;

  logic [6:0]      w_opcode, w_funct7;
  logic [2:0]      w_funct3;
  logic [4:0]      w_rs1f, w_rs2f, w_rdf;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [3:0]      w_f3_op;
  logic            w_bad;
  bundle_t         w_dec;
  logic            w_in_fire;

  bundle_t         r_main, r_skid;
  logic            r_main_valid;
  logic            r_in_ready;

  assign w_opcode = i_instr[6:0];
  assign w_rdf    = i_instr[11:7];
  assign w_funct3 = i_instr[14:12];
  assign w_rs1f   = i_instr[19:15];
  assign w_rs2f   = i_instr[24:20];
  assign w_funct7 = i_instr[31:25];

  assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_u = {i_instr[31:12], 12'h000};
  assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

  // Shared funct3 -> op map for OP and OP-IMM (funct7 picks SUB/SRA separately)
  always_comb begin
    case (w_funct3)
      3'b000:  w_f3_op = OP_ADD;
      3'b001:  w_f3_op = OP_SLL;
      3'b010:  w_f3_op = OP_SLT;
      3'b011:  w_f3_op = OP_SLTU;
      3'b100:  w_f3_op = OP_XOR;
      3'b101:  w_f3_op = OP_SRL;
      3'b110:  w_f3_op = OP_OR;
      default: w_f3_op = OP_AND;
    endcase
  end

  always_comb begin
    w_dec = '0;
    w_bad = 1'b0;
    case (w_opcode)
      7'b0110011: begin
        w_dec.rs1 = w_rs1f;  w_dec.rs2 = w_rs2f;  w_dec.rd = w_rdf;
        w_dec.reg_write = 1'b1;
        if (w_funct7 == 7'h00)                          w_dec.alu_op = w_f3_op;
        else if (w_funct7 == 7'h20 && w_funct3 == 3'b000) w_dec.alu_op = OP_SUB;
        else if (w_funct7 == 7'h20 && w_funct3 == 3'b101) w_dec.alu_op = OP_SRA;
        else                                            w_bad = 1'b1;
      end
      7'b0010011: begin
        w_dec.rs1 = w_rs1f;  w_dec.rd = w_rdf;  w_dec.imm = w_imm_i;
        w_dec.src2_imm = 1'b1;  w_dec.reg_write = 1'b1;
        w_dec.alu_op = w_f3_op;
        if (w_funct3 == 3'b001 && w_funct7 != 7'h00) w_bad = 1'b1;
        if (w_funct3 == 3'b101) begin
          if (w_funct7 == 7'h20)      w_dec.alu_op = OP_SRA;
          else if (w_funct7 != 7'h00) w_bad = 1'b1;
        end
      end
      7'b0110111, 7'b0010111: begin
        w_dec.rd = w_rdf;  w_dec.imm = w_imm_u;
        w_dec.src2_imm = 1'b1;  w_dec.reg_write = 1'b1;
        w_dec.src1_pc = w_opcode[5] ? 1'b0 : 1'b1;
      end
      7'b1101111: begin
        w_dec.rd = w_rdf;  w_dec.imm = w_imm_j;
        w_dec.src1_pc = 1'b1;  w_dec.src2_imm = 1'b1;  w_dec.jump = 1'b1;  w_dec.reg_write = 1'b1;
      end
      7'b1100111: begin
        w_dec.rs1 = w_rs1f;  w_dec.rd = w_rdf;  w_dec.imm = w_imm_i;
        w_dec.src2_imm = 1'b1;  w_dec.jump = 1'b1;  w_dec.reg_write = 1'b1;
        if (w_funct3 != 3'b000) w_bad = 1'b1;
      end
      7'b1100011: begin
        w_dec.rs1 = w_rs1f;  w_dec.rs2 = w_rs2f;  w_dec.imm = w_imm_b;
        w_dec.branch = 1'b1;  w_dec.branch_cond = w_funct3;
        if (!w_funct3[2])       w_dec.alu_op = OP_SUB;
        else if (!w_funct3[1])  w_dec.alu_op = OP_SLT;
        else                    w_dec.alu_op = OP_SLTU;
        if (w_funct3[2:1] == 2'b01) w_bad = 1'b1;
      end
      7'b0000011: begin
        w_dec.rs1 = w_rs1f;  w_dec.rd = w_rdf;  w_dec.imm = w_imm_i;
        w_dec.src2_imm = 1'b1;  w_dec.mem_read = 1'b1;  w_dec.reg_write = 1'b1;
        if (w_funct3 == 3'b011 || w_funct3[2:1] == 2'b11) w_bad = 1'b1;
      end
      7'b0100011: begin
        w_dec.rs1 = w_rs1f;  w_dec.rs2 = w_rs2f;  w_dec.imm = w_imm_s;
        w_dec.src2_imm = 1'b1;  w_dec.mem_write = 1'b1;
        if (w_funct3[2] || w_funct3[1:0] == 2'b11) w_bad = 1'b1;
      end
      7'b0001111: ;
      default: w_bad = 1'b1;
    endcase
    // Illegal words still travel downstream, stripped of every side effect
    if (w_bad) begin
      w_dec = '0;
      w_dec.illegal = 1'b1;
    end
    w_dec.pc = i_pc;
  end

  assign w_in_fire = i_in_valid & r_in_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (!r_main_valid || i_out_ready) begin
      if (!r_in_ready) begin
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_in_ready   <= 1'b1;
      end else if (i_in_valid) begin
        r_main       <= w_dec;
        r_main_valid <= 1'b1;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_skid     <= w_dec;
      r_in_ready <= 1'b0;
    end
  end

  assign o_in_ready    = r_in_ready;
  assign o_out_valid   = r_main_valid;
  assign o_alu_op      = r_main.alu_op;
  assign o_rs1         = r_main.rs1;
  assign o_rs2         = r_main.rs2;
  assign o_rd          = r_main.rd;
  assign o_imm         = r_main.imm;
  assign o_src1_pc     = r_main.src1_pc;
  assign o_src2_imm    = r_main.src2_imm;
  assign o_reg_write   = r_main.reg_write;
  assign o_mem_read    = r_main.mem_read;
  assign o_mem_write   = r_main.mem_write;
  assign o_jump        = r_main.jump;
  assign o_branch      = r_main.branch;
  assign o_branch_cond = r_main.branch_cond;
  assign o_illegal     = r_main.illegal;
  assign o_pc_out      = r_main.pc;

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb/tb_alu_decode_stage.sv - self-checking bench for alu_decode_stage
// Random instructions are assembled from fields, so the expected decode comes from the encoder side.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, pc, imm, pc_out;
  logic [3:0]  alu_op;
  logic [4:0]  rs1, rs2, rd;
  logic        src1_pc, src2_imm, reg_write, mem_read, mem_write, jump, branch, illegal;
  logic [2:0]  branch_cond;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_decode_stage dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_instr(instr), .i_pc(pc), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_alu_op(alu_op), .o_rs1(rs1), .o_rs2(rs2), .o_rd(rd), .o_imm(imm),
    .o_src1_pc(src1_pc), .o_src2_imm(src2_imm), .o_reg_write(reg_write),
    .o_mem_read(mem_read), .o_mem_write(mem_write), .o_jump(jump), .o_branch(branch),
    .o_branch_cond(branch_cond), .o_illegal(illegal), .o_pc_out(pc_out)
  );

  typedef struct packed {
    logic [3:0]  alu_op;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        src1_pc, src2_imm, reg_write, mem_read, mem_write, jump, branch;
    logic [2:0]  branch_cond;
    logic        illegal;
    logic [31:0] pc;
  } bundle_t;

  typedef struct packed {
    bundle_t b;
    logic    dc;
  } exp_t;

  exp_t q[$];

  function automatic bundle_t dut_out();
    bundle_t b;
    b.alu_op = alu_op;  b.rs1 = rs1;  b.rs2 = rs2;  b.rd = rd;  b.imm = imm;
    b.src1_pc = src1_pc;  b.src2_imm = src2_imm;  b.reg_write = reg_write;
    b.mem_read = mem_read;  b.mem_write = mem_write;  b.jump = jump;  b.branch = branch;
    b.branch_cond = branch_cond;  b.illegal = illegal;  b.pc = pc_out;
    return b;
  endfunction

  // Index and immediate fields are unspecified for illegal and fence words
  function automatic bundle_t masked(bundle_t b, logic dc);
    if (dc) begin
      b.rs1 = '0;  b.rs2 = '0;  b.rd = '0;  b.imm = '0;
    end
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_instr(output logic [31:0] w, output logic [31:0] p, output exp_t x);
    logic [4:0]  r1, r2, rdx;
    logic [11:0] i12;
    logic [19:0] u20;
    logic [12:0] b13;
    logic [20:0] j21;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [3:0]  op;
    int k, s;
    r1 = 5'($urandom);  r2 = 5'($urandom);  rdx = 5'($urandom);
    i12 = 12'($urandom);  u20 = 20'($urandom);
    b13 = {12'($urandom), 1'b0};  j21 = {20'($urandom), 1'b0};
    p = $urandom;  x = '0;  x.b.pc = p;  w = '0;  f7 = '0;  f3 = '0;  op = '0;
    k = $urandom_range(0, 11);
    case (k)
      0: begin
        s = $urandom_range(0, 9);
        case (s)
          0: {f7, f3, op} = {7'h00, 3'd0, 4'd0};
          1: {f7, f3, op} = {7'h20, 3'd0, 4'd1};
          2: {f7, f3, op} = {7'h00, 3'd1, 4'd2};
          3: {f7, f3, op} = {7'h00, 3'd2, 4'd3};
          4: {f7, f3, op} = {7'h00, 3'd3, 4'd4};
          5: {f7, f3, op} = {7'h00, 3'd4, 4'd5};
          6: {f7, f3, op} = {7'h00, 3'd5, 4'd6};
          7: {f7, f3, op} = {7'h20, 3'd5, 4'd7};
          8: {f7, f3, op} = {7'h00, 3'd6, 4'd8};
          default: {f7, f3, op} = {7'h00, 3'd7, 4'd9};
        endcase
        w = {f7, r2, r1, f3, rdx, 7'h33};
        x.b.alu_op = op;  x.b.rs1 = r1;  x.b.rs2 = r2;  x.b.rd = rdx;  x.b.reg_write = 1'b1;
      end
      1: begin
        s = $urandom_range(0, 8);
        case (s)
          0: {f3, op} = {3'd0, 4'd0};
          1: {f3, op} = {3'd2, 4'd3};
          2: {f3, op} = {3'd3, 4'd4};
          3: {f3, op} = {3'd4, 4'd5};
          4: {f3, op} = {3'd6, 4'd8};
          5: {f3, op} = {3'd7, 4'd9};
          6: {f3, op} = {3'd1, 4'd2};
          7: {f3, op} = {3'd5, 4'd6};
          default: {f3, op} = {3'd5, 4'd7};
        endcase
        if (s == 6 || s == 7) i12[11:5] = 7'h00;
        if (s == 8) i12[11:5] = 7'h20;
        w = {i12, r1, f3, rdx, 7'h13};
        x.b.alu_op = op;  x.b.rs1 = r1;  x.b.rd = rdx;  x.b.imm = 32'($signed(i12));
        x.b.src2_imm = 1'b1;  x.b.reg_write = 1'b1;
      end
      2, 3: begin
        w = {u20, rdx, (k == 2) ? 7'h37 : 7'h17};
        x.b.rd = rdx;  x.b.imm = 32'(u20) << 12;  x.b.src2_imm = 1'b1;  x.b.reg_write = 1'b1;
        x.b.src1_pc = (k == 3);
      end
      4: begin
        w = {j21[20], j21[10:1], j21[11], j21[19:12], rdx, 7'h6f};
        x.b.rd = rdx;  x.b.imm = 32'($signed(j21));  x.b.src1_pc = 1'b1;  x.b.src2_imm = 1'b1;
        x.b.jump = 1'b1;  x.b.reg_write = 1'b1;
      end
      5: begin
        w = {i12, r1, 3'b000, rdx, 7'h67};
        x.b.rs1 = r1;  x.b.rd = rdx;  x.b.imm = 32'($signed(i12));  x.b.src2_imm = 1'b1;
        x.b.jump = 1'b1;  x.b.reg_write = 1'b1;
      end
      6: begin
        s = $urandom_range(0, 5);
        f3 = (s < 2) ? 3'(s) : 3'(s + 2);
        w = {b13[12], b13[10:5], r2, r1, f3, b13[4:1], b13[11], 7'h63};
        x.b.alu_op = (f3 < 2) ? 4'd1 : (f3 < 6) ? 4'd3 : 4'd4;
        x.b.rs1 = r1;  x.b.rs2 = r2;  x.b.imm = 32'($signed(b13));
        x.b.branch = 1'b1;  x.b.branch_cond = f3;
      end
      7: begin
        s = $urandom_range(0, 4);
        f3 = (s < 3) ? 3'(s) : 3'(s + 1);
        w = {i12, r1, f3, rdx, 7'h03};
        x.b.rs1 = r1;  x.b.rd = rdx;  x.b.imm = 32'($signed(i12));  x.b.src2_imm = 1'b1;
        x.b.mem_read = 1'b1;  x.b.reg_write = 1'b1;
      end
      8: begin
        f3 = 3'($urandom_range(0, 2));
        w = {i12[11:5], r2, r1, f3, i12[4:0], 7'h23};
        x.b.rs1 = r1;  x.b.rs2 = r2;  x.b.imm = 32'($signed(i12));  x.b.src2_imm = 1'b1;
        x.b.mem_write = 1'b1;
      end
      9: begin
        w = {i12, r1, 3'b000, rdx, 7'h0f};
        x.dc = 1'b1;
      end
      default: begin
        s = $urandom_range(0, 8);
        case (s)
          0: begin
            case ($urandom_range(0, 3))
              0: f7 = 7'h7f;
              1: f7 = 7'h73;
              2: f7 = 7'h2f;
              default: f7 = 7'h57;
            endcase
            w = {25'($urandom), f7};
          end
          1: w = {7'h01, r2, r1, 3'($urandom), rdx, 7'h33};
          2: begin
            s = $urandom_range(0, 5);
            f3 = (s < 4) ? 3'(s + 1) : 3'(s + 2);
            w = {7'h20, r2, r1, f3, rdx, 7'h33};
          end
          3: w = {7'($urandom_range(1, 127)), i12[4:0], r1, 3'b001, rdx, 7'h13};
          4: begin
            case ($urandom_range(0, 3))
              0: f7 = 7'h01;
              1: f7 = 7'h10;
              2: f7 = 7'h40;
              default: f7 = 7'h21;
            endcase
            w = {f7, i12[4:0], r1, 3'b101, rdx, 7'h13};
          end
          5: w = {b13[12], b13[10:5], r2, r1, 3'($urandom_range(2, 3)), b13[4:1], b13[11], 7'h63};
          6: w = {i12, r1, 3'($urandom_range(1, 7)), rdx, 7'h67};
          7: begin
            s = $urandom_range(0, 2);
            f3 = (s == 0) ? 3'd3 : 3'(s + 5);
            w = {i12, r1, f3, rdx, 7'h03};
          end
          default: w = {i12[11:5], r2, r1, 3'($urandom_range(3, 7)), i12[4:0], 7'h23};
        endcase
        x.b.illegal = 1'b1;  x.dc = 1'b1;
      end
    endcase
  endtask

  task automatic test_reset();
    rst = 1'b1;  in_valid = 1'b0;  out_ready = 1'b0;  instr = '0;  pc = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (dut_out() !== '0) begin failures++; $display("FAIL reset_payload got=%h exp=0", dut_out()); end
  endtask

  task automatic test_single_add();
    bundle_t e;
    tick();
    instr = 32'h002081B3;  pc = 32'h100;  in_valid = 1'b1;  out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    e = '0;  e.rs1 = 5'd1;  e.rs2 = 5'd2;  e.rd = 5'd3;  e.reg_write = 1'b1;  e.pc = 32'h100;
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%b exp=1", out_valid); end
    checks++;
    if (dut_out() !== e) begin failures++; $display("FAIL add_bundle got=%h exp=%h", dut_out(), e); end
    tick();
  endtask

  task automatic test_back_to_back();
    bundle_t e;
    instr = 32'h402081B3;  pc = 32'h200;  in_valid = 1'b1;  out_ready = 1'b1;
    tick();
    instr = 32'h40335293;  pc = 32'h204;
    @(negedge clk);
    e = '0;  e.alu_op = 4'd1;  e.rs1 = 5'd1;  e.rs2 = 5'd2;  e.rd = 5'd3;  e.reg_write = 1'b1;  e.pc = 32'h200;
    checks++;
    if (out_valid !== 1'b1 || dut_out() !== e) begin
      failures++; $display("FAIL b2b_sub got=%b/%h exp=1/%h", out_valid, dut_out(), e);
    end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    e = '0;  e.alu_op = 4'd7;  e.rs1 = 5'd6;  e.rd = 5'd5;  e.imm = 32'h403;
    e.src2_imm = 1'b1;  e.reg_write = 1'b1;  e.pc = 32'h204;
    checks++;
    if (out_valid !== 1'b1 || dut_out() !== e) begin
      failures++; $display("FAIL b2b_srai got=%b/%h exp=1/%h", out_valid, dut_out(), e);
    end
    tick();
  endtask

  task automatic test_branch();
    bundle_t e;
    instr = 32'hFE20CCE3;  pc = 32'h300;  in_valid = 1'b1;  out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    e = '0;  e.alu_op = 4'd3;  e.rs1 = 5'd1;  e.rs2 = 5'd2;  e.imm = 32'hFFFFFFF8;
    e.branch = 1'b1;  e.branch_cond = 3'd4;  e.pc = 32'h300;
    checks++;
    if (out_valid !== 1'b1 || dut_out() !== e) begin
      failures++; $display("FAIL blt got=%b/%h exp=1/%h", out_valid, dut_out(), e);
    end
    tick();
  endtask

  task automatic test_illegal();
    bundle_t e;
    instr = 32'h0000007F;  pc = 32'h400;  in_valid = 1'b1;  out_ready = 1'b1;
    tick();
    instr = 32'h402091B3;  pc = 32'h404;
    @(negedge clk);
    e = '0;  e.illegal = 1'b1;  e.pc = 32'h400;
    checks++;
    if (out_valid !== 1'b1 || masked(dut_out(), 1'b1) !== e) begin
      failures++; $display("FAIL illegal_opcode got=%b/%h exp=1/%h", out_valid, dut_out(), e);
    end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    e.pc = 32'h404;
    checks++;
    if (out_valid !== 1'b1 || masked(dut_out(), 1'b1) !== e) begin
      failures++; $display("FAIL illegal_funct got=%b/%h exp=1/%h", out_valid, dut_out(), e);
    end
    tick();
  endtask

  task automatic test_stall();
    logic [31:0] w [3];
    logic [31:0] p [3];
    exp_t x [3];
    for (int i = 0; i < 3; i++) gen_instr(w[i], p[i], x[i]);
    out_ready = 1'b0;  in_valid = 1'b1;  instr = w[0];  pc = p[0];
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_ready0 got=%b exp=1", in_ready); end
    tick();
    instr = w[1];  pc = p[1];
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || masked(dut_out(), x[0].dc) !== masked(x[0].b, x[0].dc)) begin
      failures++; $display("FAIL stall_main got=%b%b/%h exp=11/%h", in_ready, out_valid, dut_out(), x[0].b);
    end
    tick();
    instr = w[2];  pc = p[2];
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || masked(dut_out(), x[0].dc) !== masked(x[0].b, x[0].dc)) begin
        failures++; $display("FAIL stall_hold got=%b%b/%h exp=01/%h", in_ready, out_valid, dut_out(), x[0].b);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || masked(dut_out(), x[i].dc) !== masked(x[i].b, x[i].dc)) begin
        failures++; $display("FAIL stall_order%0d got=%b/%h exp=1/%h", i, out_valid, dut_out(), x[i].b);
      end
      checks++;
      if (in_ready !== (i != 0)) begin failures++; $display("FAIL stall_inready%0d got=%b exp=%b", i, in_ready, i != 0); end
      tick();
      if (i == 1) in_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL stall_drained got=%b%b exp=01", out_valid, in_ready);
    end
  endtask

  task automatic test_random_stream();
    localparam int N = 300;
    logic [31:0] nw, np;
    exp_t nx, x;
    bundle_t prev;
    logic prev_stall;
    int sent, got;
    sent = 0;  got = 0;  prev_stall = 1'b0;  prev = '0;
    q.delete();
    gen_instr(nw, np, nx);
    for (int cyc = 0; cyc < 6000 && got < N; cyc++) begin
      tick();
      in_valid = (sent < N) && ($urandom_range(0, 3) != 0);
      instr = nw;  pc = np;
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      checks++;
      if (in_ready !== (q.size() < 2)) begin
        failures++; $display("FAIL rnd_in_ready got=%b exp=%b occ=%0d", in_ready, q.size() < 2, q.size());
      end
      checks++;
      if (out_valid !== (q.size() > 0)) begin
        failures++; $display("FAIL rnd_out_valid got=%b exp=%b occ=%0d", out_valid, q.size() > 0, q.size());
      end
      if (prev_stall) begin
        checks++;
        if (dut_out() !== prev) begin failures++; $display("FAIL rnd_hold got=%h exp=%h", dut_out(), prev); end
      end
      if (out_valid === 1'b1 && out_ready) begin
        got++;
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL rnd_spurious got=%h exp=none", dut_out());
        end else begin
          x = q.pop_front();
          if (masked(dut_out(), x.dc) !== masked(x.b, x.dc)) begin
            failures++; $display("FAIL rnd_bundle item=%0d got=%h exp=%h", got, dut_out(), x.b);
          end
        end
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev = dut_out();
      if (in_valid && in_ready === 1'b1) begin
        q.push_back(nx);
        sent++;
        gen_instr(nw, np, nx);
      end
    end
    checks++;
    if (got != N) begin failures++; $display("FAIL rnd_timeout got=%0d exp=%0d", got, N); end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset_full();
    logic [31:0] w, p;
    exp_t x;
    out_ready = 1'b0;
    gen_instr(w, p, x);
    in_valid = 1'b1;  instr = w;  pc = p;
    tick();
    gen_instr(w, p, x);
    instr = w;  pc = p;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      failures++; $display("FAIL rstfull_precond got=%b%b exp=01", in_ready, out_valid);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dut_out() !== '0) begin
      failures++; $display("FAIL rstfull_state got=%b%b/%h exp=01/0", out_valid, in_ready, dut_out());
    end
    tick();
    out_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rstfull_skid_dropped got=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_branch();
    test_illegal();
    test_stall();
    test_random_stream();
    test_reset_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- Registered decode stage that sits in front of the ALU and drives its op code and operand selects.
- Takes a fetched RV32I instruction and its PC over a valid/ready handshake.
- Produces the 4-bit ALU op, register indices, sign-extended immediate and control flags for the execute stage.
- A 2-entry output buffer (main register plus skid register) gives full throughput with registered in_ready.

Parameters:
- XLEN, 32, data/PC width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instr/pc valid
- in_ready  out  1  stage can accept this cycle
- instr  in  32  instruction word
- pc  in  32  instruction address
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute stage accepts bundle
- alu_op  out  4  ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9
- rs1, rs2, rd  out  5 each  register indices
- imm  out  32  sign-extended immediate
- src1_pc  out  1  ALU in_1 = pc_out, else rs1 value
- src2_imm  out  1  ALU in_2 = imm, else rs2 value
- reg_write, mem_read, mem_write, jump, branch  out  1 each  control flags
- branch_cond  out  3  funct3 of a branch, else 0
- illegal  out  1  undecodable instruction
- pc_out  out  32  registered pc

Behaviour:
- Reset:
  - out_valid=0, in_ready=1, skid empty.
  - Every payload output = 0, which gives alu_op=ADD.
  - Reset mid-operation drops both buffered entries.
- Handshake:
  - Input transfer when in_valid&in_ready.
  - Output transfer when out_valid&out_ready.
  - Latency 1 cycle: a transfer in cycle N appears on the outputs in cycle N+1.
  - Sustained throughput 1 per cycle when out_ready=1.
- Buffer rules:
  - in_ready is a registered signal, equal to "skid empty".
  - Main register empty, or main draining this cycle: the decoded input loads into main.
  - Main full and stalled (out_ready=0) with an input transfer: the input goes to skid; in_ready=0 from the next cycle.
  - Skid full and main drains: skid moves to main, skid empties, in_ready=1 next cycle.
  - No input is accepted while skid is full.
  - Outputs hold stable while out_valid=1 and out_ready=0.
  - Order is always preserved.
- Decode by opcode (imm formats follow standard RV32I I/S/B/U/J):
  - OP 0110011: src2_imm=0, reg_write=1. funct7=0x00 maps funct3 000..111 to ADD,SLL,SLT,SLTU,XOR,SRL,OR,AND. funct7=0x20 with funct3 000 is SUB, with funct3 101 is SRA. Any other funct7/funct3 pair is illegal.
  - OP-IMM 0010011: src2_imm=1, reg_write=1, I-imm, same funct3 map as OP. SLLI requires imm[11:5]=0. SRLI/SRAI require imm[11:5]=0x00 or 0x20. Otherwise illegal.
  - LUI 0110111: ADD, rs1 forced 0, src2_imm=1, U-imm, reg_write=1.
  - AUIPC 0010111: ADD, src1_pc=1, src2_imm=1, U-imm, reg_write=1.
  - JAL 1101111: ADD, src1_pc=1, src2_imm=1, J-imm, jump=1, reg_write=1.
  - JALR 1100111 (funct3 must be 000): ADD, src2_imm=1, I-imm, jump=1, reg_write=1.
  - BRANCH 1100011: B-imm, branch=1, branch_cond=funct3. BEQ/BNE map to SUB, BLT/BGE to SLT, BLTU/BGEU to SLTU. funct3 010/011 is illegal.
  - LOAD 0000011 (funct3 000,001,010,100,101): ADD, src2_imm=1, I-imm, mem_read=1, reg_write=1.
  - STORE 0100011 (funct3 000..010): ADD, src2_imm=1, S-imm, mem_write=1.
  - MISC-MEM 0001111: legal no-op; all flags 0.
  - Any other opcode, including SYSTEM: illegal.
- Illegal handling:
  - illegal=1, alu_op=ADD, and every write/mem/jump/branch flag = 0.
  - The bundle is still passed downstream; traps are handled elsewhere.
- Unused index fields:
  - rs2=0 for I/U/J formats.
  - rd=0 for S/B formats.
  - rs1=0 for U/J formats.

Test Plan:
- Single ADD: instr 0x002081B3 at pc 0x100, out_ready=1 -> next cycle out_valid=1, alu_op=0, rs1=1, rs2=2, rd=3, src2_imm=0, reg_write=1, pc_out=0x100.
- Back-to-back SUB: 0x402081B3 then SRAI 0x40335293 -> consecutive cycles show alu_op=1, then alu_op=7 with rs1=6, rd=5, imm=0x403, src2_imm=1.
- BLT x1,x2,-8 (0xFE20CCE3) -> alu_op=3, branch=1, branch_cond=4, imm=0xFFFFFFF8, reg_write=0.
- Stall: hold out_ready=0 and send 3 instructions -> first held in main, second in skid, in_ready=0 for the third. Release out_ready -> all three emerge in order with no loss or duplicates, and in_ready returns to 1.
- Illegal: 0x0000007F and 0x402091B3 -> illegal=1, alu_op=0, all flags 0, out_valid=1.
- Reset with main and skid both full -> next cycle out_valid=0, in_ready=1, all outputs 0.
